// File: rtl/display_pkg.sv
// Shared constants, state type and helpers for the 7-segment display path.
package display_pkg;

  localparam int BLANK_CNT_W = 4;

  localparam logic [3:0] ANODES_OFF = 4'b1111;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } disp_state_e;

  // True when exactly one anode is enabled (active-low one-cold)
  function automatic logic is_one_cold(input logic [3:0] an);
    return (an == 4'b1110) || (an == 4'b1101) ||
           (an == 4'b1011) || (an == 4'b0111);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder with a blank override.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg_n
);

  // Blank wins; codes above 9 render as a dash so bad counts are visible
  always_comb begin
    seg_n = SEG_DASH;
    if (blank) begin
      seg_n = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg_n = SEG_0;
        4'd1:    seg_n = SEG_1;
        4'd2:    seg_n = SEG_2;
        4'd3:    seg_n = SEG_3;
        4'd4:    seg_n = SEG_4;
        4'd5:    seg_n = SEG_5;
        4'd6:    seg_n = SEG_6;
        4'd7:    seg_n = SEG_7;
        4'd8:    seg_n = SEG_8;
        4'd9:    seg_n = SEG_9;
        default: seg_n = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_driver.sv
// 7-segment driver: frame-coherent digit capture, anti-ghosting blank gap
// at every anode change, leading-zero blanking and anode error detection.
module seg_display_driver
  import display_pkg::*;
#(
  parameter int BLANK_CYCLES = 4,
  parameter int LZ_BLANK     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an_in_n,
  input  logic       dp_in_n,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       anode_err
);

  // Counter counts down to zero, so the reload is one less than the gap
  localparam logic [BLANK_CNT_W-1:0] CNT_RELOAD =
    BLANK_CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  logic [3:0]             an_q, an_d;
  logic [3:0]             an_prev_q, an_prev_d;
  logic                   dp_q, dp_d;
  disp_state_e            state_q, state_d;
  logic [BLANK_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]             tgt_q, tgt_d;
  logic [3:0]             sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
  logic [3:0]             an_n_q, an_n_d;
  logic [6:0]             seg_n_q, seg_n_d;
  logic                   dp_n_q, dp_n_d;
  logic                   err_q, err_d;

  logic                   capture;
  logic                   restart;
  logic [3:0]             digit_val;
  logic                   digit_blank;
  logic [6:0]             dec_seg_n;

  // Input stage, frame capture and error pulse detection
  always_comb begin
    an_d      = an_in_n;
    dp_d      = dp_in_n;
    an_prev_d = an_q;
    capture   = (an_in_n == 4'b1110) && (an_q != 4'b1110);
    sh0_d     = capture ? d0 : sh0_q;
    sh1_d     = capture ? d1 : sh1_q;
    sh2_d     = capture ? d2 : sh2_q;
    sh3_d     = capture ? d3 : sh3_q;
    err_d     = !is_one_cold(an_q) && (an_q != ANODES_OFF) && (an_q != an_prev_q);
  end

  // Next-state logic: any anode change restarts the blank gap toward the newest target
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    restart = 1'b0;
    if (!is_one_cold(an_q)) begin
      state_d = IDLE;
      cnt_d   = '0;
      tgt_d   = ANODES_OFF;
    end else begin
      case (state_q)
        IDLE:    restart = 1'b1;
        SHOW:    restart = (an_q != tgt_q);
        BLANK: begin
          if (an_q != tgt_q) begin
            restart = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q - BLANK_CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      if (restart) begin
        tgt_d   = an_q;
        cnt_d   = CNT_RELOAD;
        state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
      end
    end
  end

  // Pick the shadow digit for the anode about to be driven
  always_comb begin
    digit_val   = sh0_q;
    digit_blank = 1'b0;
    case (tgt_d)
      4'b1110: digit_val = sh0_q;
      4'b1101: digit_val = sh1_q;
      4'b1011: digit_val = sh2_q;
      4'b0111: begin
        digit_val   = sh3_q;
        digit_blank = (LZ_BLANK != 0) && (sh3_q == 4'd0);
      end
      default: digit_val = sh0_q;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd   (digit_val),
    .blank (digit_blank),
    .seg_n (dec_seg_n)
  );

  // Outputs are driven only in SHOW, otherwise everything is dark
  always_comb begin
    an_n_d  = ANODES_OFF;
    seg_n_d = SEG_BLANK;
    dp_n_d  = 1'b1;
    if (state_d == SHOW) begin
      an_n_d  = tgt_d;
      seg_n_d = dec_seg_n;
      dp_n_d  = dp_q;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q      <= ANODES_OFF;
      an_prev_q <= ANODES_OFF;
      dp_q      <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      tgt_q     <= ANODES_OFF;
      sh0_q     <= '0;
      sh1_q     <= '0;
      sh2_q     <= '0;
      sh3_q     <= '0;
      an_n_q    <= ANODES_OFF;
      seg_n_q   <= SEG_BLANK;
      dp_n_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      an_q      <= an_d;
      an_prev_q <= an_prev_d;
      dp_q      <= dp_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      sh2_q     <= sh2_d;
      sh3_q     <= sh3_d;
      an_n_q    <= an_n_d;
      seg_n_q   <= seg_n_d;
      dp_n_q    <= dp_n_d;
      err_q     <= err_d;
    end
  end

  assign an_n      = an_n_q;
  assign seg_n     = seg_n_q;
  assign dp_n      = dp_n_q;
  assign anode_err = err_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver: two instances (4-cycle gap with
// leading-zero blanking, and zero gap without it) share one input stream.
module tb_seg_display_driver;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] an_in_n;
  logic       dp_in_n;
  logic [3:0] d0, d1, d2, d3;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic       err_a, err_b;

  int total = 0;
  int bad   = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Abstract model: registered anode, previous anode, registered dp,
  // edge index of the last anode change, and the frame-captured digits
  int         cyc       = 0;
  logic [3:0] m_an      = 4'hF;
  logic [3:0] m_prev    = 4'hF;
  logic       m_dp      = 1'b1;
  int         m_changed = 0;
  int         m_sh[4]   = '{0, 0, 0, 0};

  seg_display_driver #(.BLANK_CYCLES(4), .LZ_BLANK(1)) dut_a (
    .clk(clk), .rst(rst), .an_in_n(an_in_n), .dp_in_n(dp_in_n),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .an_n(an_a), .seg_n(seg_a), .dp_n(dp_a), .anode_err(err_a)
  );

  seg_display_driver #(.BLANK_CYCLES(0), .LZ_BLANK(0)) dut_b (
    .clk(clk), .rst(rst), .an_in_n(an_in_n), .dp_in_n(dp_in_n),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .an_n(an_b), .seg_n(seg_b), .dp_n(dp_b), .anode_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Output expected after the current edge, given the gap length and LZ mode
  function automatic exp_t predict(input int gap, input bit lz);
    exp_t e;
    int   idx;
    int   v;
    bit   legal;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    legal = ($countones(~m_an) == 1);
    e.err = !legal && (m_an != 4'hF) && (m_an != m_prev);
    if (legal && (cyc >= m_changed + 1 + gap)) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!m_an[i]) idx = i;
      v     = m_sh[idx];
      e.an  = m_an;
      e.dp  = m_dp;
      e.seg = (lz && idx == 3 && v == 0) ? 7'h7F : seg_of(v);
    end
    return e;
  endfunction

  task automatic modelEdge();
    exp_t ea;
    exp_t eb;
    cyc++;
    if (rst) begin
      ea.an = 4'hF; ea.seg = 7'h7F; ea.dp = 1'b1; ea.err = 1'b0;
      eb = ea;
      m_an = 4'hF; m_prev = 4'hF; m_dp = 1'b1; m_changed = cyc;
      for (int i = 0; i < 4; i++) m_sh[i] = 0;
    end else begin
      ea = predict(4, 1'b1);
      eb = predict(0, 1'b0);
      if (an_in_n != m_an) begin
        m_changed = cyc;
        if (an_in_n == 4'b1110) begin
          m_sh[0] = int'(d0); m_sh[1] = int'(d1);
          m_sh[2] = int'(d2); m_sh[3] = int'(d3);
        end
      end
      m_prev = m_an;
      m_an   = an_in_n;
      m_dp   = dp_in_n;
    end
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic applyStimulus(input logic [3:0] an, input logic dp,
                               input logic [15:0] dv, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      an_in_n = an;
      dp_in_n = dp;
      {d3, d2, d1, d0} = dv;
      rst = r;
      @(posedge clk);
      modelEdge();
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e, input logic [3:0] an,
                             input logic [6:0] seg, input logic dp, input logic err);
    total += 4;
    if (an !== e.an) begin
      bad++;
      $display("[TB] FAIL %s_an cyc=%0d got=%b want=%b", tag, cyc, an, e.an);
    end
    if (seg !== e.seg) begin
      bad++;
      $display("[TB] FAIL %s_seg cyc=%0d got=%b want=%b", tag, cyc, seg, e.seg);
    end
    if (dp !== e.dp) begin
      bad++;
      $display("[TB] FAIL %s_dp cyc=%0d got=%b want=%b", tag, cyc, dp, e.dp);
    end
    if (err !== e.err) begin
      bad++;
      $display("[TB] FAIL %s_err cyc=%0d got=%b want=%b", tag, cyc, err, e.err);
    end
  endtask

  // Monitor: outputs are registered every edge, so one expectation per edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        checkOutput("A", e, an_a, seg_a, dp_a, err_a);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        checkOutput("B", e, an_b, seg_b, dp_b, err_b);
      end
    end
  end

  initial begin
    logic [3:0]  ran;
    logic [15:0] rdv;
    int          sel;
    rst = 1'b1; an_in_n = 4'hF; dp_in_n = 1'b1;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;

    $display("[TB] reset and first digit");
    applyStimulus(4'hF, 1'b1, 16'h0000, 1'b1, 2);
    applyStimulus(4'b1110, 1'b1, 16'h4321, 1'b0, 8);

    $display("[TB] frame coherence across a full rotation");
    applyStimulus(4'b0111, 1'b1, 16'h4321, 1'b0, 12);
    applyStimulus(4'b1011, 1'b0, 16'h4321, 1'b0, 12);
    applyStimulus(4'b1101, 1'b1, 16'h4321, 1'b0, 12);
    applyStimulus(4'b1110, 1'b1, 16'h5678, 1'b0, 1);
    applyStimulus(4'b1110, 1'b1, 16'h9012, 1'b0, 11);
    applyStimulus(4'b0111, 1'b1, 16'h9012, 1'b0, 12);
    applyStimulus(4'b1011, 1'b1, 16'h9012, 1'b0, 12);
    applyStimulus(4'b1101, 1'b1, 16'h9012, 1'b0, 12);
    applyStimulus(4'b1110, 1'b1, 16'h9012, 1'b0, 12);

    $display("[TB] leading zero and invalid code");
    applyStimulus(4'b1101, 1'b1, 16'h0123, 1'b0, 6);
    applyStimulus(4'b1110, 1'b1, 16'h0123, 1'b0, 6);
    applyStimulus(4'b0111, 1'b0, 16'h0123, 1'b0, 10);
    applyStimulus(4'b1110, 1'b1, 16'hB12C, 1'b0, 6);
    applyStimulus(4'b0111, 1'b1, 16'hB12C, 1'b0, 10);

    $display("[TB] illegal anode and recovery");
    applyStimulus(4'b1101, 1'b1, 16'h0000, 1'b0, 10);
    applyStimulus(4'b1100, 1'b1, 16'h0000, 1'b0, 3);
    applyStimulus(4'b1000, 1'b1, 16'h0000, 1'b0, 3);
    applyStimulus(4'b1101, 1'b1, 16'h0000, 1'b0, 10);

    $display("[TB] anode change during blank gap");
    applyStimulus(4'b1011, 1'b1, 16'h0000, 1'b0, 10);
    applyStimulus(4'b1101, 1'b1, 16'h0000, 1'b0, 2);
    applyStimulus(4'b0111, 1'b1, 16'h0000, 1'b0, 10);

    $display("[TB] reset while showing");
    applyStimulus(4'b1101, 1'b0, 16'h0000, 1'b0, 10);
    applyStimulus(4'b1101, 1'b0, 16'h0000, 1'b1, 1);
    applyStimulus(4'b1101, 1'b0, 16'h0000, 1'b0, 10);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        ran = 4'hF;
        ran[$urandom_range(0, 3)] = 1'b0;
      end else if (sel == 6) begin
        ran = 4'hF;
      end else begin
        ran = 4'($urandom_range(0, 15));
      end
      rdv = 16'($urandom);
      applyStimulus(ran, 1'($urandom_range(0, 1)), rdv,
                    ($urandom_range(0, 29) == 0), $urandom_range(1, 14));
    end
    applyStimulus(4'hF, 1'b1, 16'h0000, 1'b0, 3);

    @(negedge clk);
    #1;
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d/%0d want=0/0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display_driver.md
# seg_display_driver

Downstream consumer of the rotating digit-enable stage in the stopwatch display path. Takes the active-low one-cold anode vector and decimal-point enable, plus four BCD digits from the stopwatch counter. Drives the physical 7-segment anodes, cathodes and decimal point. Adds three things on top of a plain mux:
- Frame-coherent digit capture, so a displayed value never tears across digits.
- A programmable all-off blanking gap at every anode change, to suppress ghosting.
- Leading-zero blanking and invalid-code display.

## Interface
Parameters:
- BLANK_CYCLES, 4, all-off cycles inserted at each anode change; legal range 0..15.
- LZ_BLANK, 1, when 1, the most significant digit (digit 3) is blanked while its captured value is 0.

Ports:
- clk  in  1  single clock for the block; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- an_in_n  in  4  anode enables from the rotation stage, active-low, one-cold; bit 0 = least significant digit.
- dp_in_n  in  1  decimal-point enable, active-low.
- d0, d1, d2, d3  in  4 each  BCD digit values; d0 is least significant.
- an_n  out  4  registered anode drive, active-low.
- seg_n  out  7  registered cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- dp_n  out  1  registered decimal-point cathode, active-low.
- anode_err  out  1  one-cycle pulse when the registered an_in_n is neither one-cold nor 4'b1111.

## Operation
- Input stage: an_in_n and dp_in_n are registered every cycle into an_q and dp_q. All decisions use the registered copies.
- Frame capture: when an_q changes to 4'b1110 (start of frame, digit 0), d0..d3 are captured into shadow registers sh0..sh3. The digit inputs are sampled at that same edge. The shadows are not updated at any other time.
- FSM states:
  - IDLE: outputs off. Entered at reset.
  - BLANK: outputs off, blank counter running.
  - SHOW: the selected digit is displayed.
- FSM transitions:
  - IDLE → BLANK when an_q is legal one-cold.
  - SHOW → BLANK when an_q differs from the currently displayed anode.
  - BLANK → SHOW when the counter expires.
  - Any state → IDLE when an_q is 4'b1111 or illegal.
  - If an_q changes again during BLANK, the counter reloads and the newest an_q becomes the target.
- Selection in SHOW:
  - an_n = target anode.
  - seg_n = decode of the shadow digit at the active bit position.
  - dp_n = dp_q.
- Decode rules:
  - Values 0..9 map to standard patterns, e.g. 0 → 7'b1000000, 8 → 7'b0000000.
  - Values 10..15 map to dash, 7'b0111111.
  - When LZ_BLANK = 1 and sh3 = 0, digit 3 shows 7'b1111111. Its dp still follows dp_q.
- Off condition (IDLE, BLANK): an_n = 4'b1111, seg_n = 7'b1111111, dp_n = 1.
- anode_err is asserted in the cycle after an_q becomes illegal. It re-asserts for each new illegal value.

## Timing
- Reset: an_n = 4'b1111, seg_n = 7'b1111111, dp_n = 1, anode_err = 0, state IDLE, sh0..sh3 = 0, an_q = 4'b1111, dp_q = 1, blank counter = 0.
- Reset asserted mid-BLANK or mid-SHOW takes effect at the next edge. There is no partial output.
- Input change sequence:
  - A change on an_in_n registers into an_q at edge k.
  - The outputs are off after edge k+1, for BLANK_CYCLES cycles.
  - The new digit is driven after edge k+1+BLANK_CYCLES.
- BLANK_CYCLES = 0: the new digit is driven after edge k+1 with no off gap.
- Frame capture and a digit-input change at the same edge: the shadow takes the value present at that edge.
- Upstream rotation period must be at least BLANK_CYCLES+2 clk cycles. Faster rotation keeps the block in BLANK permanently (outputs off), which is legal.

## Structure
- Shared package display_pkg contains:
  - Segment constants SEG_0..SEG_9, SEG_DASH and SEG_BLANK.
  - ANODES_OFF = 4'b1111.
  - The FSM state enum {IDLE, BLANK, SHOW}.
  - The blank counter width (4).
- One sub-module, bcd_to_seg: combinational 4-bit BCD to seg_n decoder with a blank input. The top contains the registers, FSM, shadow digits and selection.

## Test plan
- Reset, then an_in_n = 4'b1110 with d0..d3 = 1,2,3,4 and BLANK_CYCLES = 4 → an_n = 4'b1111 for 4 cycles, then an_n = 4'b1110, seg_n = 7'b1111001.
- Full rotation 1110→0111→1011→1101, 12 cycles per digit; d0..d3 change after digit 0 starts → all four digits show the values captured at the frame start; new values appear only on the next frame.
- d3 = 0, LZ_BLANK = 1, digit 3 active → seg_n = 7'b1111111, an_n = 4'b0111. With d3 = 0xB and LZ_BLANK = 0 → seg_n = 7'b0111111.
- an_in_n = 4'b1100 → anode_err pulses for 1 cycle; outputs go off (IDLE). Returning to 4'b1101 → a BLANK_CYCLES gap, then digit 1 is shown.
- Anode change mid-BLANK (2 cycles in) → the counter reloads; the off period lasts 4 cycles from the second change; the second anode is displayed.
- rst pulsed while in SHOW with dp_in_n = 0 → at the next edge all outputs are off, dp_n = 1, and the shadows read 0.
